rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port among NUM_REQ writeback sources (ALU, load unit, ...).
//  Round-robin arbitration with valid/ready handshake per requester.
//  Registered output drives the register file's regwrite / write_reg / write_data.
//  Writes to x0 are accepted and then squashed, so x0 stays zero.
// PARAMETERS
//  NUM_REQ  2   number of writeback requesters (2..8)
//  DATA_W   32  register data width
//  ADDR_W   5   register index width (32 registers)
//  CNT_W    16  width of stall statistics counter
// PORTS
//  clock          in   1                 single clock, rising edge
//  reset          in   1                 synchronous, active-low reset
//  req_valid      in   NUM_REQ           requester i has a write pending
//  req_ready      out  NUM_REQ           requester i accepted this cycle
//  req_addr       in   NUM_REQ*ADDR_W    packed dest reg index, slice i = [i*ADDR_W +: ADDR_W]
//  req_data       in   NUM_REQ*DATA_W    packed write data, slice i = [i*DATA_W +: DATA_W]
//  rf_regwrite    out  1                 write enable to register file
//  rf_write_reg   out  ADDR_W            write index to register file
//  rf_write_data  out  DATA_W            write data to register file
//  grant_id       out  $clog2(NUM_REQ)   index of requester whose write is on rf_* outputs
//  stall_cnt      out  CNT_W             saturating count of cycles with >=1 valid requester not granted
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - rf_regwrite=0, rf_write_reg=0, rf_write_data=0, grant_id=0, stall_cnt=0.
//   - RR pointer last=NUM_REQ-1, so requester 0 has top priority first.
//   - req_ready is 0 while reset is low.
//  Arbitration (combinational):
//   - Among valid requesters, grant the first found scanning last+1, last+2, ... (mod NUM_REQ).
//   - req_ready[i]=1 for the granted i only; one-hot or zero.
//   - The output stage never stalls, so ready does not depend on downstream.
//  Handshake:
//   - Transfer when req_valid[i] && req_ready[i].
//   - A requester holds valid, addr and data stable until it is accepted. No retraction.
//  Output stage, 1-cycle latency (registered):
//   - On transfer: rf_regwrite<=(addr!=0), rf_write_reg<=addr, rf_write_data<=data, grant_id<=i, last<=i.
//   - No transfer: rf_regwrite<=0; rf_write_reg, rf_write_data and grant_id hold; last holds.
//  x0: the transfer completes (ready=1) but rf_regwrite stays 0.
//  Same destination from two requesters in one cycle: only one is granted; the other writes next cycle.
//   The final value comes from the later-granted requester (RR order).
//  Single requester continuously valid: granted every cycle, full throughput.
//  stall_cnt: +1 each cycle (|req_valid) && (popcount(req_valid)>1). Saturates at all-ones; no wrap.
//  Reset mid-operation: an in-flight registered write is discarded.
//   rf_regwrite is 0 in the cycle after reset is sampled low; the pointer reinitialises.
// STRUCTURE
//  Shared package (rf_pkg): REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
//  Sub-module rr_arbiter (NUM_REQ): inputs req and last pointer; outputs one-hot grant and encoded index.
//  Top level: rr_arbiter, payload mux, output registers, pointer register, saturating counter.
// TESTING
//  1 Reset low 2 cycles, all valid=0 -> rf_regwrite=0, stall_cnt=0, req_ready=0.
//  2 Req0 valid addr=5 data=32'hDEAD_BEEF -> ready0=1 same cycle; next cycle rf_regwrite=1, reg=5, data=DEADBEEF, grant_id=0.
//  3 Req0 and req1 both valid for 4 cycles, distinct data -> grants alternate 0,1,0,1.
//     stall_cnt=4; every accepted write appears exactly once, 1 cycle later.
//  4 Req1 valid addr=0 data=7 -> ready1=1; next cycle rf_regwrite=0.
//  5 Both write addr=9, req0=1 and req1=2, from reset -> rf_write_data=1 then 2; final visible value is 2.
//  6 Transfer accepted, then reset low on the next edge -> rf_regwrite=0 that cycle; after release req0 wins first.
//  Also: force stall_cnt near max (CNT_W=4 variant) -> holds at 15; randomized handshake with a scoreboard check.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file geometry for the write arbiter
package rf_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rtl/rf_write_arbiter_if.sv - writeback requester bundle and register-file write port
interface rf_write_arbiter_if
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int CNT_W   = 16
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      rf_regwrite;
   logic [ADDR_W-1:0]         rf_write_reg;
   logic [DATA_W-1:0]         rf_write_data;
   logic [IDX_W-1:0]          grant_id;
   logic [CNT_W-1:0]          stall_cnt;

   modport master (
      output req_valid, req_addr, req_data,
      input  req_ready, rf_regwrite, rf_write_reg, rf_write_data, grant_id, stall_cnt
   );

   modport slave (
      input  req_valid, req_addr, req_data,
      output req_ready, rf_regwrite, rf_write_reg, rf_write_data, grant_id, stall_cnt
   );
endinterface

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// rtl/rf_write_arbiter_rr_arbiter.sv - round-robin grant scanning from last+1
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);
   // Scan farthest-first so the nearest valid requester after last overwrites the rest.
   always_comb begin
      int c;
      grant = '0;
      idx   = '0;
      c     = 0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         c = int'(last) + k;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (req[c]) begin
            grant    = '0;
            grant[c] = 1'b1;
            idx      = IDX_W'(c);
         end
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - shares the register-file write port among writeback sources
module rf_write_arbiter
   import rf_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int CNT_W   = 16
) (
   input  logic            clock,
   input  logic            reset,
   rf_write_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   last;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_data;
   logic               transfer;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req   (bus.req_valid),
      .last  (last),
      .grant (grant),
      .idx   (idx)
   );

   // The output stage never back-pressures, so ready is simply the grant outside reset.
   assign bus.req_ready = reset ? grant : '0;
   assign transfer      = reset && (|grant);
   assign sel_addr      = bus.req_addr[int'(idx)*ADDR_W +: ADDR_W];
   assign sel_data      = bus.req_data[int'(idx)*DATA_W +: DATA_W];

   always_ff @(posedge clock) begin
      if (!reset) begin
         bus.rf_regwrite   <= 1'b0;
         bus.rf_write_reg  <= '0;
         bus.rf_write_data <= '0;
         bus.grant_id      <= '0;
         bus.stall_cnt     <= '0;
         last              <= IDX_W'(NUM_REQ - 1);
      end else begin
         bus.rf_regwrite <= 1'b0;
         if (transfer) begin
            // x0 writes complete the handshake but never reach the register file.
            bus.rf_regwrite   <= (sel_addr != ADDR_W'(REG_ZERO));
            bus.rf_write_reg  <= sel_addr;
            bus.rf_write_data <= sel_data;
            bus.grant_id      <= idx;
            last              <= idx;
         end
         if (($countones(bus.req_valid) > 1) && (bus.stall_cnt != {CNT_W{1'b1}}))
            bus.stall_cnt <= bus.stall_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clock = ~clock;

   rf_write_arbiter_if #(.NUM_REQ(2), .CNT_W(16)) a ();
   rf_write_arbiter_if #(.NUM_REQ(3), .CNT_W(4))  b ();

   rf_write_arbiter #(.NUM_REQ(2), .CNT_W(16)) dut_a (.clock(clock), .reset(reset), .bus(a));
   rf_write_arbiter #(.NUM_REQ(3), .CNT_W(4))  dut_b (.clock(clock), .reset(reset), .bus(b));

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      a.req_valid = '0; a.req_addr = '0; a.req_data = '0;
      b.req_valid = '0; b.req_addr = '0; b.req_data = '0;
      @(posedge clock);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clock);
      reset = 1'b0;
      a.req_valid = 2'b11; a.req_addr = {5'd3, 5'd4}; a.req_data = {32'h2, 32'h1};
      b.req_valid = '0; b.req_addr = '0; b.req_data = '0;
      #1;
      vectors++;
      if (a.req_ready !== 2'b00) begin
         miscompares++; $display("FAIL reset_ready got=%b exp=00", a.req_ready);
      end
      @(posedge clock); @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b0 || a.stall_cnt !== 16'd0 || a.rf_write_reg !== 5'd0 ||
          a.rf_write_data !== 32'd0 || a.grant_id !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state got we=%b cnt=%0d reg=%0d data=%h gid=%0d exp all zero",
                  a.rf_regwrite, a.stall_cnt, a.rf_write_reg, a.rf_write_data, a.grant_id);
      end
      @(negedge clock);
      a.req_valid = '0;
      reset = 1'b1;
   endtask

   task automatic test_single_write();
      do_reset();
      @(negedge clock);
      a.req_valid = 2'b01; a.req_addr = {5'd0, 5'd5}; a.req_data = {32'h0, 32'hDEAD_BEEF};
      #1;
      vectors++;
      if (a.req_ready !== 2'b01) begin
         miscompares++; $display("FAIL single_ready got=%b exp=01", a.req_ready);
      end
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b1 || a.rf_write_reg !== 5'd5 || a.rf_write_data !== 32'hDEAD_BEEF ||
          a.grant_id !== 1'b0) begin
         miscompares++;
         $display("FAIL single_out got we=%b reg=%0d data=%h gid=%0d exp 1 5 deadbeef 0",
                  a.rf_regwrite, a.rf_write_reg, a.rf_write_data, a.grant_id);
      end
      @(negedge clock);
      a.req_valid = 2'b00;
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b0 || a.rf_write_reg !== 5'd5 || a.rf_write_data !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL single_idle got we=%b reg=%0d data=%h exp 0 5 deadbeef",
                  a.rf_regwrite, a.rf_write_reg, a.rf_write_data);
      end
   endtask

   task automatic test_alternate();
      int n[2];
      logic [31:0] d0, d1, exp_d;
      n[0] = 0; n[1] = 0;
      do_reset();
      for (int c = 0; c < 4; c++) begin
         int g;
         g = c % 2;
         d0 = 32'hA000_0000 + 32'(n[0]);
         d1 = 32'hB100_0000 + 32'(n[1]);
         @(negedge clock);
         a.req_valid = 2'b11; a.req_addr = {5'd2, 5'd1}; a.req_data = {d1, d0};
         #1;
         vectors++;
         if (a.req_ready !== 2'(1 << g)) begin
            miscompares++; $display("FAIL alt_ready c=%0d got=%b exp=%b", c, a.req_ready, 2'(1 << g));
         end
         exp_d = (g == 0) ? d0 : d1;
         @(posedge clock); #1;
         vectors++;
         if (a.rf_regwrite !== 1'b1 || a.grant_id !== 1'(g) || a.rf_write_data !== exp_d ||
             a.rf_write_reg !== 5'(g + 1)) begin
            miscompares++;
            $display("FAIL alt_out c=%0d got we=%b gid=%0d data=%h reg=%0d exp 1 %0d %h %0d",
                     c, a.rf_regwrite, a.grant_id, a.rf_write_data, a.rf_write_reg, g, exp_d, g + 1);
         end
         n[g]++;
      end
      @(negedge clock);
      a.req_valid = 2'b00;
      @(posedge clock); #1;
      vectors++;
      if (a.stall_cnt !== 16'd4 || a.rf_regwrite !== 1'b0) begin
         miscompares++; $display("FAIL alt_stall got cnt=%0d we=%b exp 4 0", a.stall_cnt, a.rf_regwrite);
      end
   endtask

   task automatic test_x0();
      do_reset();
      @(negedge clock);
      a.req_valid = 2'b10; a.req_addr = {5'd0, 5'd0}; a.req_data = {32'd7, 32'd0};
      #1;
      vectors++;
      if (a.req_ready !== 2'b10) begin
         miscompares++; $display("FAIL x0_ready got=%b exp=10", a.req_ready);
      end
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b0 || a.grant_id !== 1'b1 || a.rf_write_data !== 32'd7) begin
         miscompares++;
         $display("FAIL x0_out got we=%b gid=%0d data=%h exp 0 1 7", a.rf_regwrite, a.grant_id, a.rf_write_data);
      end
      @(negedge clock);
      a.req_valid = 2'b00;
   endtask

   task automatic test_same_dest();
      do_reset();
      @(negedge clock);
      a.req_valid = 2'b11; a.req_addr = {5'd9, 5'd9}; a.req_data = {32'd2, 32'd1};
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b1 || a.rf_write_reg !== 5'd9 || a.rf_write_data !== 32'd1) begin
         miscompares++;
         $display("FAIL same_first got we=%b reg=%0d data=%h exp 1 9 1", a.rf_regwrite, a.rf_write_reg, a.rf_write_data);
      end
      @(negedge clock);
      a.req_valid = 2'b10;
      @(posedge clock); #1;
      @(negedge clock);
      a.req_valid = 2'b00;
      @(posedge clock); #1;
      vectors++;
      if (a.rf_write_reg !== 5'd9 || a.rf_write_data !== 32'd2 || a.grant_id !== 1'b1) begin
         miscompares++;
         $display("FAIL same_final got reg=%0d data=%h gid=%0d exp 9 2 1", a.rf_write_reg, a.rf_write_data, a.grant_id);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      @(negedge clock);
      a.req_valid = 2'b01; a.req_addr = {5'd6, 5'd3}; a.req_data = {32'h66, 32'h33};
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b1) begin
         miscompares++; $display("FAIL mid_accept got we=%b exp 1", a.rf_regwrite);
      end
      @(negedge clock);
      reset = 1'b0;
      a.req_valid = 2'b11;
      @(posedge clock); #1;
      vectors++;
      if (a.rf_regwrite !== 1'b0 || a.req_ready !== 2'b00) begin
         miscompares++; $display("FAIL mid_reset got we=%b rdy=%b exp 0 00", a.rf_regwrite, a.req_ready);
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      vectors++;
      if (a.req_ready !== 2'b01) begin
         miscompares++; $display("FAIL mid_restart got rdy=%b exp 01", a.req_ready);
      end
      @(negedge clock);
      a.req_valid = 2'b00;
   endtask

   task automatic test_saturation();
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         @(negedge clock);
         b.req_valid = 3'b111; b.req_addr = {5'd3, 5'd2, 5'd1}; b.req_data = {32'h3, 32'h2, 32'h1};
         @(posedge clock); #1;
         if (c == 14 || c == 15 || c == 20) begin
            int e;
            e = (c > 15) ? 15 : c;
            vectors++;
            if (b.stall_cnt !== 4'(e)) begin
               miscompares++; $display("FAIL sat_cnt c=%0d got=%0d exp=%0d", c, b.stall_cnt, e);
            end
         end
      end
      @(negedge clock);
      b.req_valid = '0;
   endtask

   task automatic test_random();
      logic [2:0]  pv;
      logic [4:0]  pa[3];
      logic [31:0] pd[3];
      int          mlast, mcnt, g;
      logic        e_we;
      logic [4:0]  e_reg;
      logic [31:0] e_data;
      int          e_gid;
      do_reset();
      pv = '0; mlast = 2; mcnt = 0; e_reg = '0; e_data = '0; e_gid = 0;
      for (int i = 0; i < 3; i++) begin pa[i] = '0; pd[i] = '0; end
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            if (!pv[i] && $urandom_range(0, 1) == 1) begin
               pv[i] = 1'b1;
               pa[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
               pd[i] = $urandom;
            end
            b.req_addr[i*5 +: 5]  = pa[i];
            b.req_data[i*32 +: 32] = pd[i];
         end
         b.req_valid = pv;
         #1;
         g = -1;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (mlast + k) % 3;
            if (g < 0 && pv[c]) g = c;
         end
         vectors++;
         if (b.req_ready !== ((g >= 0) ? 3'(1 << g) : 3'b000)) begin
            miscompares++; $display("FAIL rnd_ready n=%0d got=%b exp_idx=%0d", n, b.req_ready, g);
         end
         if ($countones(pv) > 1 && mcnt < 15) mcnt++;
         e_we = 1'b0;
         if (g >= 0) begin
            e_we = (pa[g] != 5'd0); e_reg = pa[g]; e_data = pd[g]; e_gid = g;
            mlast = g; pv[g] = 1'b0;
         end
         @(posedge clock); #1;
         vectors++;
         if (b.rf_regwrite !== e_we || b.rf_write_reg !== e_reg || b.rf_write_data !== e_data ||
             b.grant_id !== 2'(e_gid) || b.stall_cnt !== 4'(mcnt)) begin
            miscompares++;
            $display("FAIL rnd_out n=%0d got we=%b reg=%0d data=%h gid=%0d cnt=%0d exp %b %0d %h %0d %0d",
                     n, b.rf_regwrite, b.rf_write_reg, b.rf_write_data, b.grant_id, b.stall_cnt,
                     e_we, e_reg, e_data, e_gid, mcnt);
         end
      end
      @(negedge clock);
      b.req_valid = '0;
   endtask

   initial begin
      a.req_valid = '0; a.req_addr = '0; a.req_data = '0;
      b.req_valid = '0; b.req_addr = '0; b.req_data = '0;
      test_reset();
      test_single_write();
      test_alternate();
      test_x0();
      test_same_dest();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
